// File: rtl/wrc_phy_link_emu.sv
// wrc_phy_link_emu: PHY TX-to-RX loopback with programmable latency, link lock sequencing and error injection
module wrc_phy_link_emu #(
   parameter int g_data_width  = 8,
   parameter int g_max_delay   = 64,
   parameter int g_lock_cycles = 128
) (
   input  logic                             clk_ref_i,
   input  logic                             rst_i,
   input  logic [g_data_width-1:0]          tx_data_i,
   input  logic [g_data_width/8-1:0]        tx_k_i,
   output logic [g_data_width-1:0]          rx_data_o,
   output logic [g_data_width/8-1:0]        rx_k_o,
   output logic [g_data_width/8-1:0]        rx_enc_err_o,
   output logic [4:0]                       rx_bitslide_o,
   output logic [g_data_width/8-1:0]        tx_disparity_o,
   output logic [g_data_width/8-1:0]        tx_enc_err_o,
   input  logic                             cfg_link_up_i,
   input  logic [$clog2(g_max_delay)-1:0]   cfg_delay_i,
   input  logic [4:0]                       cfg_bitslide_i,
   input  logic                             inj_err_p_i,
   input  logic                             cnt_clr_p_i,
   output logic                             locked_o,
   output logic [15:0]                      err_count_o
);
   localparam int L  = g_data_width / 8;
   localparam int AW = $clog2(g_max_delay);
   localparam int CW = $clog2(g_lock_cycles) + 1;

   if (g_lock_cycles < g_max_delay) begin : g_bad_lock
      $error("g_lock_cycles must be >= g_max_delay");
   end
   if (g_data_width != 8 && g_data_width != 16) begin : g_bad_width
      $error("g_data_width must be 8 or 16");
   end

   typedef enum logic [1:0] {DOWN, LOCKING, UP} state_t;
   state_t st, st_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [AW-1:0] d_lat, d_nxt, wr_ptr, rd_ptr;
   logic [g_data_width-1:0] mem_data [g_max_delay];
   logic [L-1:0] mem_k [g_max_delay];
   logic mem_err [g_max_delay];
   logic err_in;

   assign err_in = inj_err_p_i && st == UP;
   // Read is of the old contents at this edge, so one less than D gives D+1 cycles of latency
   assign rd_ptr = wr_ptr - d_lat - AW'(1);
   assign tx_disparity_o = '0;
   assign tx_enc_err_o = '0;

   always_comb begin
      st_nxt = st;
      cnt_nxt = cnt;
      d_nxt = d_lat;
      if (!cfg_link_up_i) begin
         st_nxt = DOWN;
      end else if (st == DOWN || (st == UP && cfg_delay_i != d_lat)) begin
         st_nxt = LOCKING;
         d_nxt = cfg_delay_i;
         cnt_nxt = CW'(g_lock_cycles - 1);
      end else if (st == LOCKING) begin
         st_nxt = cnt == '0 ? UP : LOCKING;
         cnt_nxt = cnt == '0 ? cnt : cnt - CW'(1);
      end
   end

   always_ff @(posedge clk_ref_i or posedge rst_i) begin
      if (rst_i) begin
         st <= DOWN;
         cnt <= '0;
         d_lat <= '0;
      end else begin
         st <= st_nxt;
         cnt <= cnt_nxt;
         d_lat <= d_nxt;
      end
   end

   always_ff @(posedge clk_ref_i) begin
      mem_data[wr_ptr] <= tx_data_i ^ g_data_width'(err_in);
      mem_k[wr_ptr] <= tx_k_i;
      mem_err[wr_ptr] <= err_in;
   end

   always_ff @(posedge clk_ref_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rx_data_o <= '0;
         rx_k_o <= '0;
         rx_enc_err_o <= '1;
         rx_bitslide_o <= '0;
         locked_o <= 1'b0;
         err_count_o <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(1);
         rx_data_o <= st_nxt == UP ? mem_data[rd_ptr] : '0;
         rx_k_o <= st_nxt == UP ? mem_k[rd_ptr] : '0;
         rx_enc_err_o <= st_nxt == UP ? L'(mem_err[rd_ptr]) : '1;
         rx_bitslide_o <= st_nxt == UP ? cfg_bitslide_i : '0;
         locked_o <= st_nxt == UP;
         err_count_o <= cnt_clr_p_i ? '0 :
                        (st == UP && rx_enc_err_o[0] && err_count_o != 16'hFFFF) ? err_count_o + 16'd1 :
                        err_count_o;
      end
   end
endmodule

// File: tb/tb_wrc_phy_link_emu.sv
// tb_wrc_phy_link_emu: directed vectors and sequences for the PHY link loopback model
module tb_wrc_phy_link_emu;
   logic clk = 1'b0;
   logic rst, link_up, clr, inj8, inj16;
   logic [5:0] cfg_delay;
   logic [4:0] bitslide;
   logic [7:0] tx8, rx8;
   logic k8, rk8, ee8, dp8, te8, lk8;
   logic [15:0] tx16, rx16, cnt8, cnt16;
   logic [1:0] k16, rk16, ee16, dp16, te16;
   logic [4:0] bs8, bs16;
   logic lk16;
   int total = 0;
   int bad = 0;

   typedef struct {
      logic inj;
      logic [7:0] data;
      logic k;
      logic [7:0] exp_data;
      logic exp_k;
      logic exp_err;
      logic [15:0] exp_cnt;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   wrc_phy_link_emu #(.g_data_width(8)) dut8 (
      .clk_ref_i(clk), .rst_i(rst), .tx_data_i(tx8), .tx_k_i(k8),
      .rx_data_o(rx8), .rx_k_o(rk8), .rx_enc_err_o(ee8), .rx_bitslide_o(bs8),
      .tx_disparity_o(dp8), .tx_enc_err_o(te8), .cfg_link_up_i(link_up),
      .cfg_delay_i(cfg_delay), .cfg_bitslide_i(bitslide), .inj_err_p_i(inj8),
      .cnt_clr_p_i(clr), .locked_o(lk8), .err_count_o(cnt8));

   wrc_phy_link_emu #(.g_data_width(16)) dut16 (
      .clk_ref_i(clk), .rst_i(rst), .tx_data_i(tx16), .tx_k_i(k16),
      .rx_data_o(rx16), .rx_k_o(rk16), .rx_enc_err_o(ee16), .rx_bitslide_o(bs16),
      .tx_disparity_o(dp16), .tx_enc_err_o(te16), .cfg_link_up_i(link_up),
      .cfg_delay_i(cfg_delay), .cfg_bitslide_i(bitslide), .inj_err_p_i(inj16),
      .cnt_clr_p_i(clr), .locked_o(lk16), .err_count_o(cnt16));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      logic [15:0] prev_cnt;
      vecs[0] = '{1'b1, 8'hBC, 1'b1, 8'hBD, 1'b1, 1'b1, 16'd1};
      vecs[1] = '{1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0, 16'd1};
      vecs[2] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 16'd2};
      vecs[3] = '{1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 16'd2};
      vecs[4] = '{1'b1, 8'hFE, 1'b0, 8'hFF, 1'b0, 1'b1, 16'd3};
      rst = 1'b1; link_up = 1'b0; clr = 1'b0; inj8 = 1'b0; inj16 = 1'b0;
      cfg_delay = 6'd5; bitslide = 5'h07; tx8 = '0; k8 = 1'b0; tx16 = '0; k16 = '0;
      repeat (2) step;
      chk("rst_rx_data", rx8, 0);
      chk("rst_enc_err8", ee8, 1);
      chk("rst_enc_err16", ee16, 2'b11);
      chk("rst_locked", lk8, 0);
      chk("rst_cnt", cnt8, 0);
      chk("rst_bitslide", bs8, 0);
      chk("tx_disp_enc", {dp16, te16}, 0);
      rst = 1'b0;
      link_up = 1'b1;
      repeat (128) step;
      chk("lock_not_yet", lk8, 0);
      chk("lock_enc_err", ee8, 1);
      chk("lock_bitslide", bs8, 0);
      step;
      chk("lock_done", lk8, 1);
      chk("lock_bitslide_up", bs8, 5'h07);
      chk("lock16_done", lk16, 1);
      for (int i = 0; i < 30; i++) begin
         tx8 = 8'(i);
         step;
         if (i >= 6) begin
            chk("stream_data", rx8, 32'(i - 6));
            chk("stream_err", {rk8, ee8}, 0);
         end
      end
      tx8 = '0;
      repeat (8) step;
      prev_cnt = '0;
      for (int i = 0; i < 5; i++) begin
         inj8 = vecs[i].inj; tx8 = vecs[i].data; k8 = vecs[i].k;
         step;
         inj8 = 1'b0; tx8 = '0; k8 = 1'b0;
         repeat (6) step;
         chk("vec_data", rx8, vecs[i].exp_data);
         chk("vec_k", rk8, vecs[i].exp_k);
         chk("vec_err", ee8, vecs[i].exp_err);
         chk("vec_cnt_pre", cnt8, prev_cnt);
         step;
         chk("vec_cnt", cnt8, vecs[i].exp_cnt);
         prev_cnt = vecs[i].exp_cnt;
      end
      inj8 = 1'b1; tx8 = 8'h10;
      step;
      tx8 = 8'h20;
      step;
      inj8 = 1'b0; tx8 = '0;
      repeat (5) step;
      chk("b2b_first", {rx8, ee8}, {8'h11, 1'b1});
      chk("b2b_cnt0", cnt8, 3);
      step;
      chk("b2b_second", {rx8, ee8}, {8'h21, 1'b1});
      chk("b2b_cnt1", cnt8, 4);
      step;
      chk("b2b_cnt2", cnt8, 5);
      chk("b2b_clean", ee8, 0);
      inj16 = 1'b1; tx16 = 16'hABCD; k16 = 2'b10;
      step;
      inj16 = 1'b0; tx16 = '0; k16 = '0;
      repeat (6) step;
      chk("w16_data", rx16, 16'hABCC);
      chk("w16_k", rk16, 2'b10);
      chk("w16_err", ee16, 2'b01);
      cfg_delay = 6'd0;
      step;
      chk("resync_unlock", lk8, 0);
      chk("resync_enc_err", ee8, 1);
      chk("resync_bitslide", bs8, 0);
      repeat (127) step;
      chk("resync_not_yet", {lk8, ee8}, 2'b01);
      step;
      chk("resync_lock", lk8, 1);
      chk("resync_bs", bs8, 5'h07);
      chk("resync_cnt_kept", cnt8, 5);
      tx8 = 8'h33;
      step;
      tx8 = 8'h44;
      step;
      chk("d0_first", rx8, 8'h33);
      tx8 = '0;
      step;
      chk("d0_second", rx8, 8'h44);
      cfg_delay = 6'd3;
      repeat (88) step;
      link_up = 1'b0;
      step;
      chk("drop_locked", lk8, 0);
      chk("drop_rx", rx8, 0);
      chk("drop_enc_err", ee8, 1);
      link_up = 1'b1;
      repeat (128) step;
      chk("relock_not_yet", lk8, 0);
      step;
      chk("relock_done", lk8, 1);
      chk("relock_cnt_kept", cnt8, 5);
      inj8 = 1'b1; tx8 = 8'h55;
      repeat (65540) step;
      chk("sat_cnt", cnt8, 16'hFFFF);
      chk("sat_data", rx8, 8'h54);
      clr = 1'b1;
      step;
      chk("clr_wins", cnt8, 0);
      clr = 1'b0;
      step;
      chk("clr_then_inc", cnt8, 1);
      inj8 = 1'b0;
      repeat (10) step;
      chk("drain_cnt", cnt8, 6);
      chk("drain_err", ee8, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
